edge_hold_fsm: RTL
==================

EDGE_HOLD_FSM -- requirements
Module: edge_hold_fsm

Interface
REQ-001 Parameter N_CH, default 2, number of independent input channels (N_CH >= 1).
REQ-002 Parameter HOLD, default 4, consecutive synchronized samples needed to confirm a level change (HOLD >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 A  input  N_CH  raw per-channel levels, asynchronous to clk.
REQ-006 K1  output  N_CH  one-cycle pulse per confirmed 0->1 level change, per channel.
REQ-007 K2  output  N_CH  one-cycle pulse per confirmed 1->0 level change, per channel.
REQ-008 level  output  N_CH  current confirmed (debounced) level per channel.

Function
REQ-009 Each channel SHALL pass A[i] through a 2-flop synchronizer; the second flop output is A_s[i].
REQ-010 Each channel SHALL run an independent FSM with states LOW, RISE, HIGH and FALL, plus a hold counter cnt of width $clog2(HOLD+1).
REQ-011 In LOW, A_s=1 SHALL go to RISE with cnt=1; if HOLD==1 it SHALL instead go directly to HIGH and pulse K1.
REQ-012 In RISE, A_s=0 SHALL return to LOW with cnt=0, with no pulse.
REQ-013 In RISE, A_s=1 with cnt==HOLD-1 SHALL go to HIGH, set cnt=0 and pulse K1; otherwise A_s=1 SHALL increment cnt.
REQ-014 HIGH and FALL SHALL mirror LOW and RISE with the polarity of A_s inverted, and FALL SHALL pulse K2 on confirmation.
REQ-015 K1 and K2 SHALL be registered, high for exactly one cycle, and never high together on the same channel.
REQ-016 Latency: if A[i] is first sampled 1 at edge e and stays 1, then K1[i] and level[i]=1 SHALL be registered at edge e+HOLD+1.
REQ-017 level[i] SHALL be 1 exactly in HIGH and FALL.
REQ-018 Channels SHALL be fully independent, and simultaneous changes on several channels SHALL produce pulses on the same edge.
REQ-019 Any glitch shorter than HOLD synchronized samples SHALL produce no pulse and no change in level.

Reset
REQ-020 While rst_n=0, all channels SHALL be held in state LOW, with cnt=0, synchronizer flops=0, K1=0, K2=0 and level=0.
REQ-021 When reset is asserted mid-RISE or mid-FALL, the pending change SHALL be discarded immediately.
REQ-022 If A is held high through reset release, a K1 pulse SHALL follow per REQ-016, with e counted from the first edge after release.

Configuration
REQ-023 With macro EDGE_HOLD_CNT_EN defined, the block SHALL add output rise_cnt (N_CH*8 bits), an 8-bit wrapping count of K1 pulses per channel.
REQ-024 rise_cnt SHALL be reset to 0 and SHALL increment on the same edge that registers K1.
REQ-025 Without EDGE_HOLD_CNT_EN, the rise_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package edge_hold_pkg SHALL hold the state encoding, Gray-coded: LOW=2'b00, RISE=2'b01, HIGH=2'b11, FALL=2'b10.
REQ-027 Package edge_hold_pkg SHALL also hold the default HOLD value and the counter-width function.
REQ-028 Sub-module edge_hold_ch SHALL implement one channel (synchronizer, FSM, counter and optional rise_cnt), and edge_hold_fsm SHALL instantiate N_CH copies in a generate loop.

Verification (N_CH=2, HOLD=4, 20 ns clock, rst_n released at 100 ns)
REQ-029 A[0]=0 for 50 cycles, then 1 for 150 cycles -> one K1[0] pulse registered at edge e+5, level[0]=1, K2[0] never asserted.
REQ-030 A[1] high for 3 cycles, then low -> no K1[1] pulse, and level[1] stays 0.
REQ-031 A[0] goes 1->0 and stays low for 500 cycles -> one K2[0] pulse at edge e+5, then level[0]=0.
REQ-032 A[0] and A[1] rise on the same cycle, A[1] falls 2 cycles after A[0] -> K1 pulses on the same edge, K2 pulses 2 edges apart.
REQ-033 rst_n driven low while channel 0 is in RISE with cnt=2, A held high, reset released -> outputs 0 during reset, then K1[0] at e+5 after release.
REQ-034 With EDGE_HOLD_CNT_EN defined, 3 rise events -> rise_cnt[7:0]=3; 256 rise events -> rise_cnt[7:0]=0.

Source files
------------

// File: rtl/edge_hold_pkg.sv
// Shared types and helpers for the edge_hold_fsm debouncer.
// Optional per-channel rise counter is enabled with macro EDGE_HOLD_CNT_EN.
package edge_hold_pkg;

  // Gray-coded so neighbouring states differ in one bit; bit 1 is the confirmed level.
  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_RISE = 2'b01,
    ST_HIGH = 2'b11,
    ST_FALL = 2'b10
  } state_e;

  localparam int unsigned HOLD_DEFAULT = 4;
  localparam int unsigned RISE_CNT_W   = 8;
  localparam int unsigned SYNC_STAGES  = 2;

  // Hold counter width for a given HOLD; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold);
    int unsigned w;
    w = (hold < 1) ? 1 : $clog2(hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_hold_ch.sv
// One debounce channel: 2-flop synchronizer, LOW/RISE/HIGH/FALL FSM and hold counter.
// With EDGE_HOLD_CNT_EN defined, also keeps an 8-bit wrapping count of confirmed rises.
module edge_hold_ch
  import edge_hold_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a,
  output logic                  k1,
  output logic                  k2,
  output logic                  level
`ifdef EDGE_HOLD_CNT_EN
  ,
  output logic [RISE_CNT_W-1:0] rise_cnt
`endif
);

  localparam int unsigned CNT_W = cnt_width(HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam bit HOLD_IS_ONE = (HOLD == 32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;
  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   confirm_rise_c;
  logic                   confirm_fall_c;

  // Bring the asynchronous level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a};
    end
  end

  assign a_s = sync_q[SYNC_STAGES-1];

  // Edges on which a level change is confirmed this cycle.
  always_comb begin
    confirm_rise_c = 1'b0;
    confirm_fall_c = 1'b0;
    case (state)
      ST_LOW:  confirm_rise_c = a_s && HOLD_IS_ONE;
      ST_RISE: confirm_rise_c = a_s && (cnt == CNT_LAST);
      ST_HIGH: confirm_fall_c = !a_s && HOLD_IS_ONE;
      ST_FALL: confirm_fall_c = !a_s && (cnt == CNT_LAST);
      default: begin
        confirm_rise_c = 1'b0;
        confirm_fall_c = 1'b0;
      end
    endcase
  end

  // Debounce FSM with registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
      k1    <= 1'b0;
      k2    <= 1'b0;
    end else begin
      k1 <= confirm_rise_c;
      k2 <= confirm_fall_c;
      case (state)
        ST_LOW: begin
          if (a_s) begin
            if (HOLD_IS_ONE) begin
              state <= ST_HIGH;
              cnt   <= '0;
            end else begin
              state <= ST_RISE;
              cnt   <= CNT_W'(1);
            end
          end
        end
        ST_RISE: begin
          if (!a_s) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (!a_s) begin
            if (HOLD_IS_ONE) begin
              state <= ST_LOW;
              cnt   <= '0;
            end else begin
              state <= ST_FALL;
              cnt   <= CNT_W'(1);
            end
          end
        end
        ST_FALL: begin
          if (a_s) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Gray encoding puts the confirmed level in state bit 1 (HIGH and FALL).
  assign level = state[1];

`ifdef EDGE_HOLD_CNT_EN
  // Counts on the same edge that registers k1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
    end else if (confirm_rise_c) begin
      rise_cnt <= rise_cnt + RISE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/edge_hold_fsm.sv
// N_CH independent debounced edge detectors with confirmed-level outputs.
// Define EDGE_HOLD_CNT_EN to add the per-channel rise_cnt output.
module edge_hold_fsm
  import edge_hold_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned HOLD = HOLD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              A,
  output logic [N_CH-1:0]              K1,
  output logic [N_CH-1:0]              K2,
  output logic [N_CH-1:0]              level
`ifdef EDGE_HOLD_CNT_EN
  ,
  output logic [N_CH*RISE_CNT_W-1:0]   rise_cnt
`endif
);

  // One fully independent channel per input bit.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_hold_ch #(
      .HOLD(HOLD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (A[i]),
      .k1      (K1[i]),
      .k2      (K2[i]),
      .level   (level[i])
`ifdef EDGE_HOLD_CNT_EN
      ,
      .rise_cnt(rise_cnt[i*RISE_CNT_W +: RISE_CNT_W])
`endif
    );
  end

endmodule
